// File: rtl/wb_obi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wb_obi_bridge
// Purpose  : Wishbone-classic responder to OBI initiator bridge. Lets an
//            external Wishbone master reach the OBI fabric. One outstanding
//            transaction, fully registered outputs, and a watchdog that turns
//            a hung OBI slave into a Wishbone error.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   wb_cyc_i/stb_i/we_i    Wishbone cycle, strobe, write enable
//   wb_sel_i, wb_adr_i     byte select, byte address
//   wb_dat_i / wb_dat_o    write data in / last read data out
//   wb_ack_o, wb_err_o     one-cycle transfer acknowledge / error
//   obi_req_o, obi_gnt_i   OBI address-phase handshake
//   obi_addr_o/we_o/be_o/wdata_o  registered OBI address-phase outputs
//   obi_rvalid_i, obi_rdata_i, obi_err_i  OBI response phase
// ============================================================================
module wb_obi_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  input  logic                    obi_err_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit C_TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_abort;

  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_abort_nxt;
  logic [DATA_WIDTH-1:0]   w_dat_nxt;
  logic                    w_ack_nxt;
  logic                    w_err_nxt;
  logic                    w_req_nxt;
  logic [ADDR_WIDTH-1:0]   w_addr_nxt;
  logic                    w_we_nxt;
  logic [BE_WIDTH-1:0]     w_be_nxt;
  logic [DATA_WIDTH-1:0]   w_wdata_nxt;

  logic                    w_timeout;
  logic                    w_abort_now;

  // The counter only advances while a transaction is in flight and stops the
  // moment it matches, so it never wraps while the watchdog is enabled.
  assign w_timeout   = C_TO_EN && (r_cnt == C_TIMEOUT);
  // Includes a cyc drop seen on this very edge, so the response that arrives
  // together with the drop is already suppressed.
  assign w_abort_now = r_abort | ~wb_cyc_i;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = r_abort;
    w_dat_nxt   = wb_dat_o;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_req_nxt   = obi_req_o;
    w_addr_nxt  = obi_addr_o;
    w_we_nxt    = obi_we_o;
    w_be_nxt    = obi_be_o;
    w_wdata_nxt = obi_wdata_o;

    unique case (r_state)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          w_addr_nxt  = wb_adr_i;
          w_we_nxt    = wb_we_i;
          w_be_nxt    = wb_sel_i;
          w_wdata_nxt = wb_dat_i;
          w_req_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_abort_nxt = 1'b0;
          w_state_nxt = S_REQ;
        end
      end

      S_REQ: begin
        w_abort_nxt = w_abort_now;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        // A grant is never refused, even after an abort: OBI forbids
        // retracting req before gnt.
        if (obi_gnt_i) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_RESP;
        end else if (w_timeout) begin
          w_req_nxt   = 1'b0;
          w_err_nxt   = ~w_abort_now;
          w_state_nxt = S_DONE;
        end
      end

      S_RESP: begin
        w_abort_nxt = w_abort_now;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (obi_rvalid_i) begin
          w_state_nxt = S_DONE;
          if (!w_abort_now) begin
            if (obi_err_i) begin
              w_err_nxt = 1'b1;
            end else begin
              w_ack_nxt = 1'b1;
              if (!obi_we_o) begin
                w_dat_nxt = obi_rdata_i;
              end
            end
          end
        end else if (w_timeout) begin
          w_err_nxt   = ~w_abort_now;
          w_state_nxt = S_DONE;
        end
      end

      // ack/err is high for exactly this state; the strobe is not sampled
      // here so the master has this cycle to drop or re-present it.
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_abort     <= 1'b0;
      wb_dat_o    <= '0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      obi_req_o   <= 1'b0;
      obi_addr_o  <= '0;
      obi_we_o    <= 1'b0;
      obi_be_o    <= '0;
      obi_wdata_o <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_abort     <= w_abort_nxt;
      wb_dat_o    <= w_dat_nxt;
      wb_ack_o    <= w_ack_nxt;
      wb_err_o    <= w_err_nxt;
      obi_req_o   <= w_req_nxt;
      obi_addr_o  <= w_addr_nxt;
      obi_we_o    <= w_we_nxt;
      obi_be_o    <= w_be_nxt;
      obi_wdata_o <= w_wdata_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_obi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_obi_bridge
// Purpose  : Self-checking bench for wb_obi_bridge. Table of transfers plus
//            hand sequences for abort, timeout and reset mid-transfer.
//            Expected Wishbone responses are queued when a transfer starts
//            and checked by a monitor when ack/err appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_obi_bridge;

  localparam int TO = 8;

  logic        clk;
  logic        rst_ni;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_w;
  logic [31:0] wb_dat_r;
  logic        wb_ack, wb_err;
  logic        obi_req, obi_gnt, obi_we, obi_rvalid, obi_err;
  logic [31:0] obi_addr, obi_wdata, obi_rdata;
  logic [3:0]  obi_be;

  wb_obi_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .wb_cyc_i    (wb_cyc),
    .wb_stb_i    (wb_stb),
    .wb_we_i     (wb_we),
    .wb_sel_i    (wb_sel),
    .wb_adr_i    (wb_adr),
    .wb_dat_i    (wb_dat_w),
    .wb_dat_o    (wb_dat_r),
    .wb_ack_o    (wb_ack),
    .wb_err_o    (wb_err),
    .obi_req_o   (obi_req),
    .obi_gnt_i   (obi_gnt),
    .obi_addr_o  (obi_addr),
    .obi_we_o    (obi_we),
    .obi_be_o    (obi_be),
    .obi_wdata_o (obi_wdata),
    .obi_rvalid_i(obi_rvalid),
    .obi_rdata_i (obi_rdata),
    .obi_err_i   (obi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          gnt_wait;
    int          rv_wait;
    logic [31:0] rdata;
    logic        err;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_lat;
  } vec_t;

  typedef struct {
    string       name;
    logic        is_err;
    logic [31:0] dat;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [31:0] adr,
                              input logic [31:0] dat, input logic [3:0] sel, input int gw,
                              input int rw, input logic [31:0] rdata, input logic err,
                              input logic exp_err, input logic [31:0] exp_dat);
    vec_t v;
    v.name = name; v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
    v.gnt_wait = gw; v.rv_wait = rw; v.rdata = rdata; v.err = err;
    v.exp_err = exp_err; v.exp_dat = exp_dat; v.exp_lat = 3 + gw + rw;
    return v;
  endfunction

  // Response monitor: every ack/err must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_ni && (wb_ack || wb_err)) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b with nothing pending", wb_ack, wb_err);
      end else begin
        e = sb.pop_front();
        chk({e.name, "/err"}, wb_err, e.is_err);
        chk({e.name, "/ack"}, wb_ack, !e.is_err);
        chk({e.name, "/dat_o"}, wb_dat_r, e.dat);
        chk({e.name, "/latency"}, cyc_cnt - e.start + 1, e.lat);
      end
    end
  end

  task automatic start_xfer(input vec_t v);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = v.we;
    wb_adr = v.adr; wb_dat_w = v.dat; wb_sel = v.sel;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    start_xfer(v);
    e.name = v.name; e.is_err = v.exp_err; e.dat = v.exp_dat;
    e.start = cyc_cnt + 1; e.lat = v.exp_lat;
    sb.push_back(e);
    step();
    chk({v.name, "/req"}, obi_req, 1);
    chk({v.name, "/addr"}, obi_addr, v.adr);
    chk({v.name, "/we"}, obi_we, v.we);
    chk({v.name, "/be"}, obi_be, v.sel);
    chk({v.name, "/wdata"}, obi_wdata, v.dat);
    for (int i = 0; i < v.gnt_wait; i++) begin
      step();
      chk({v.name, "/req_hold"}, obi_req, 1);
      chk({v.name, "/addr_hold"}, obi_addr, v.adr);
    end
    obi_gnt = 1'b1;
    step();
    obi_gnt = 1'b0;
    chk({v.name, "/req_drop"}, obi_req, 0);
    repeat (v.rv_wait) step();
    obi_rvalid = 1'b1; obi_rdata = v.rdata; obi_err = v.err;
    step();
    obi_rvalid = 1'b0; obi_rdata = 32'h0; obi_err = 1'b0;
    step();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    step();
  endtask

  vec_t tbl[6];
  vec_t v;
  exp_t e;

  initial begin
    tbl[0] = mk("zw_write",  1'b1, 32'h0008_0010, 32'hCAFE_F00D, 4'hF, 0, 0, 32'h0,          1'b0, 1'b0, 32'h0000_0000);
    tbl[1] = mk("dly_read",  1'b0, 32'h0000_0100, 32'h0,         4'hF, 2, 2, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678);
    tbl[2] = mk("err_read",  1'b0, 32'h0000_0200, 32'h0,         4'hF, 0, 1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h1234_5678);
    tbl[3] = mk("half_read", 1'b0, 32'h0000_0204, 32'h0,         4'h3, 1, 0, 32'hA5A5_0F0F, 1'b0, 1'b0, 32'hA5A5_0F0F);
    tbl[4] = mk("hi_write",  1'b1, 32'h0000_0208, 32'h1111_2222, 4'hC, 0, 3, 32'h0,          1'b0, 1'b0, 32'hA5A5_0F0F);
    tbl[5] = mk("err_write", 1'b1, 32'h0000_020C, 32'h3333_4444, 4'hF, 1, 1, 32'h0,          1'b1, 1'b1, 32'hA5A5_0F0F);

    rst_ni = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 4'h0;
    wb_adr = 32'h0; wb_dat_w = 32'h0;
    obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = 32'h0; obi_err = 1'b0;
    step();
    step();
    chk("reset_outputs", |{wb_dat_r, wb_ack, wb_err, obi_req, obi_addr, obi_we, obi_be, obi_wdata}, 0);
    rst_ni = 1'b1;
    step();

    // Stray rvalid while idle must be ignored.
    obi_rvalid = 1'b1; obi_rdata = 32'hFFFF_FFFF;
    step();
    obi_rvalid = 1'b0; obi_rdata = 32'h0;
    step();
    chk("stray_rvalid/dat_o", wb_dat_r, 32'h0);
    chk("stray_rvalid/req", obi_req, 0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Abort: cyc drops in REQ, OBI side still completes, no Wishbone response.
    v = mk("abort", 1'b0, 32'h0000_0300, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0);
    start_xfer(v);
    step();
    wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (2) begin
      step();
      chk("abort/req_hold", obi_req, 1);
    end
    obi_gnt = 1'b1;
    step();
    obi_gnt = 1'b0;
    chk("abort/req_drop", obi_req, 0);
    obi_rvalid = 1'b1; obi_rdata = 32'hBBBB_BBBB;
    step();
    obi_rvalid = 1'b0; obi_rdata = 32'h0;
    repeat (3) step();
    chk("abort/dat_kept", wb_dat_r, 32'hA5A5_0F0F);
    run_vec(mk("post_abort", 1'b0, 32'h0000_0304, 32'h0, 4'hF, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D));

    // Timeout: gnt never arrives.
    v = mk("timeout", 1'b1, 32'h0000_0400, 32'h5555_AAAA, 4'hF, 0, 0, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D);
    start_xfer(v);
    e.name = "timeout"; e.is_err = 1'b1; e.dat = 32'h0BAD_F00D;
    e.start = cyc_cnt + 1; e.lat = TO + 2;
    sb.push_back(e);
    step();
    repeat (TO) begin
      step();
      chk("timeout/req_hold", obi_req, 1);
    end
    step();
    chk("timeout/req_drop", obi_req, 0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    repeat (2) step();
    run_vec(mk("post_timeout", 1'b1, 32'h0000_0404, 32'h7777_8888, 4'hF, 0, 1, 32'h0, 1'b0, 1'b0, 32'h0BAD_F00D));

    // Reset while in RESP.
    v = mk("rst_mid", 1'b0, 32'h0000_0500, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0);
    start_xfer(v);
    step();
    obi_gnt = 1'b1;
    step();
    obi_gnt = 1'b0;
    chk("rst_mid/in_resp_req", obi_req, 0);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid/outputs_zero", |{wb_dat_r, wb_ack, wb_err, obi_req, obi_addr, obi_we, obi_be, obi_wdata}, 0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    step();
    run_vec(mk("post_reset", 1'b1, 32'h0008_0010, 32'hCAFE_F00D, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0));

    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_obi_bridge.md
# wb_obi_bridge

Wishbone-classic responder to OBI initiator bridge. Gives an external Wishbone master, such as a debug or host port, access to the core-side OBI fabric and its RAM. It sits on the SoC's inbound Wishbone interface (wb_*_i), which is the reverse of the existing OBI-to-WB path. It has one outstanding transaction, fully registered OBI outputs, and a watchdog timeout that turns a hung OBI slave into a Wishbone error.

## Interface

Parameters:
- ADDR_WIDTH, default 32: address width on both sides.
- DATA_WIDTH, default 32: data width. Fixed at 32; BE width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, default 255: cycles allowed in REQ or RESP before an error. 0 disables the timeout.

Ports:
- clk_i, in, 1: single clock.
- rst_ni, in, 1: asynchronous active-low reset.
- wb_cyc_i, in, 1: bus cycle.
- wb_stb_i, in, 1: strobe.
- wb_we_i, in, 1: write enable.
- wb_sel_i, in, 4: byte select.
- wb_adr_i, in, ADDR_WIDTH: byte address.
- wb_dat_i, in, 32: write data.
- wb_dat_o, out, 32: read data.
- wb_ack_o, out, 1: transfer acknowledge.
- wb_err_o, out, 1: transfer error.
- obi_req_o, out, 1: OBI request.
- obi_gnt_i, in, 1: OBI grant.
- obi_addr_o, out, ADDR_WIDTH: OBI address.
- obi_we_o, out, 1: OBI write enable.
- obi_be_o, out, 4: OBI byte enables.
- obi_wdata_o, out, 32: OBI write data.
- obi_rvalid_i, in, 1: OBI response valid.
- obi_rdata_i, in, 32: OBI response data.
- obi_err_i, in, 1: OBI response error, qualified by rvalid.

## Operation

- FSM states: IDLE, REQ, RESP, DONE. Reset state is IDLE.
- **IDLE**: when wb_cyc_i & wb_stb_i is sampled high, latch adr/we/sel/dat into obi_addr_o/obi_we_o/obi_be_o/obi_wdata_o, set obi_req_o=1, and go to REQ. Clear the timeout counter and the abort flag.
- **REQ**: hold obi_req_o and all OBI address-phase outputs stable until obi_gnt_i is sampled high. Then clear obi_req_o (registered, so it is low in the next cycle) and go to RESP.
- **RESP**: wait for obi_rvalid_i. On rvalid:
  - read: capture obi_rdata_i into wb_dat_o.
  - err_pending is set to obi_err_i.
  - go to DONE.
- **DONE**: drive exactly one cycle of wb_ack_o=1, or wb_err_o=1 if err_pending. Never both. Then go to IDLE.
- **Abort**: if wb_cyc_i is sampled low in REQ or RESP, set the abort flag.
  - The OBI transaction still completes: req is not retracted before gnt, and rvalid is consumed.
  - In DONE with abort set, neither ack nor err is driven, and wb_dat_o is not updated.
- **Timeout**: the counter increments each cycle in REQ/RESP. On reaching TIMEOUT_CYCLES, drop obi_req_o, set err_pending, and go to DONE. This is a recovery path.
- **Stray rvalid**: an obi_rvalid_i sampled in IDLE or REQ is ignored.
- wb_dat_o holds the last read value. Writes and errors leave it unchanged.
- Back-to-back transfers: a strobe sampled in the cycle after DONE starts a new transfer. The master must deassert or re-present stb in the cycle after ack (classic, non-pipelined).
- **Reset**: asynchronous. At any point, go to IDLE and drive every output to 0: wb_dat_o=0, wb_ack_o=0, wb_err_o=0, obi_req_o=0, obi_addr_o=0, obi_we_o=0, obi_be_o=0, obi_wdata_o=0. An in-flight OBI transaction is abandoned.

## Timing

- All outputs are registered; there is no combinational path from input to output.
- Zero-wait OBI (gnt in the first req cycle, rvalid in the next cycle), with stb first sampled at edge k:
  - req high after edge k.
  - gnt sampled at edge k+1.
  - rvalid sampled at edge k+2.
  - ack high for the cycle after edge k+2, i.e. 3 cycles stb-to-ack.
- Latency = 3 + gnt wait cycles + rvalid wait cycles.
- The timeout fires when the counter equals TIMEOUT_CYCLES. Error is asserted TIMEOUT_CYCLES+2 cycles after stb is sampled.
- Throughput is at most one transfer per 4 cycles.

## Test plan

- **Zero-wait write**: wb write adr=0x0008_0010, dat=0xCAFE_F00D, sel=0xF.
  - obi_addr_o, obi_wdata_o and obi_be_o match, with obi_we_o=1.
  - ack arrives 3 cycles after stb, for 1 cycle, with err=0.
- **Delayed read**: gnt 2 cycles late, rvalid 3 cycles after gnt, rdata=0x1234_5678.
  - ack arrives at cycle 3+2+2 with wb_dat_o=0x1234_5678.
  - obi_addr_o is stable throughout REQ.
- **OBI error**: a read answered with rvalid & err.
  - wb_err_o pulses once, wb_ack_o stays 0, and wb_dat_o is unchanged.
- **Abort**: wb_cyc_i drops while in REQ.
  - req stays high until gnt.
  - rvalid is consumed with no ack or err, and the next transfer works normally.
- **Timeout**: TIMEOUT_CYCLES=8 and gnt is never asserted.
  - obi_req_o drops.
  - wb_err_o pulses 10 cycles after stb.
  - A later transfer completes normally.
- **Reset mid-transfer**: assert rst_ni low while in RESP.
  - All outputs read 0 immediately.
  - After release, a fresh write completes in 3 cycles.
